uld_decode_pipe: RTL and testbench



---
 rtl/uld_pkg.sv | 56 +++++
 rtl/uld_decode_pipe_div.sv | 69 ++++++
 rtl/uld_decode_pipe.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_uld_decode_pipe.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uld_pkg.sv
// uld_pkg: shared types for the micro-layer descriptor decode pipe.
// Layer/FSM enums, descriptor header and decoded bundle, tile helper.
package uld_pkg;

  localparam int ULD_TILE_W = 8;

  typedef enum logic [1:0] {
    LT_PW  = 2'd0,
    LT_DW  = 2'd1,
    LT_STD = 2'd2,
    LT_LIN = 2'd3
  } layer_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DIV_R,
    S_DIV_C,
    S_DIV_TD,
    S_DIV_TK,
    S_HOLD
  } state_t;

  typedef struct packed {
    logic [5:0] layer_id;
    layer_t     ltype;
    logic [1:0] kh;
    logic [1:0] kw;
    logic [1:0] stride;
    logic [7:0] pad;
    logic [3:0] flags;
  } uld_t;

  typedef struct packed {
    logic [ULD_TILE_W-1:0] tile_d;
    logic [ULD_TILE_W-1:0] tile_k;
    logic                  err;
  } uld_dec_t;

  // returns {tile_d, tile_k}
  function automatic logic [2*ULD_TILE_W-1:0] tile_pair(
    input layer_t                t,
    input logic [ULD_TILE_W-1:0] pw,
    input logic [ULD_TILE_W-1:0] dw,
    input logic [ULD_TILE_W-1:0] st
  );
    logic [2*ULD_TILE_W-1:0] r;
    r = {pw, pw};
    unique case (1'b1)
      (t == LT_DW):  r = {8'd1, dw};
      (t == LT_STD): r = {st, st};
      default:       r = {pw, pw};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/uld_decode_pipe_div.sv
// uld_seq_div: restoring divider, one quotient bit per cycle, W >= 2.
// Ports: start/dividend/divisor in; busy, done (1-cycle pulse), quotient out.
module uld_seq_div #(
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quotient
);

  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  rem_q;
  logic [W-1:0]  quo_q;
  logic [W-1:0]  dvs_q;
  logic [W-1:0]  rem_in;
  logic [W-1:0]  quo_in;
  logic [W-1:0]  dvs_in;
  logic [W-1:0]  rem_nx;
  logic [W-1:0]  quo_nx;
  logic [W:0]    part;
  logic          ge;
  logic [CW-1:0] cnt;
  logic          done_q;

  // the start cycle already produces the first quotient bit
  always_comb begin
    rem_in = start ? '0 : rem_q;
    quo_in = start ? dividend : quo_q;
    dvs_in = start ? divisor : dvs_q;
    part   = {rem_in, quo_in[W-1]};
    ge     = part >= {1'b0, dvs_in};
    rem_nx = ge ? W'(part - {1'b0, dvs_in}) : part[W-1:0];
    quo_nx = {quo_in[W-2:0], ge};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      cnt    <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        rem_q <= rem_nx;
        quo_q <= quo_nx;
        dvs_q <= divisor;
        cnt   <= CW'(W - 1);
      end else if (cnt != '0) begin
        rem_q  <= rem_nx;
        quo_q  <= quo_nx;
        cnt    <= cnt - CW'(1);
        done_q <= (cnt == CW'(1));
      end
    end
  end

  assign busy     = (cnt != '0);
  assign done     = done_q;
  assign quotient = quo_q;

endmodule

// File: rtl/uld_decode_pipe.sv
// uld_decode_pipe: FIFO-buffered uLD decoder, one shared divider.
// in_* valid/ready -> FIFO -> FSM -> out_* valid/ready; ULD_ERR_CHECK_EN
// enables illegal-descriptor detection (out_err), otherwise out_err=0.
module uld_decode_pipe
  import uld_pkg::*;
#(
  parameter int DIM_W      = 8,
  parameter int CH_W       = 11,
  parameter int FIFO_DEPTH = 2,
  parameter int TILE_PW    = 32,
  parameter int TILE_DW    = 10,
  parameter int TILE_STD   = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       in_layer_id,
  input  logic [1:0]       in_type,
  input  logic [DIM_W-1:0] in_R,
  input  logic [DIM_W-1:0] in_C,
  input  logic [CH_W-1:0]  in_D,
  input  logic [CH_W-1:0]  in_K,
  input  logic [1:0]       in_kH,
  input  logic [1:0]       in_kW,
  input  logic [1:0]       in_stride,
  input  logic [7:0]       in_pad,
  input  logic [3:0]       in_flags,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [5:0]       out_layer_id,
  output logic [1:0]       out_type,
  output logic [1:0]       out_kH,
  output logic [1:0]       out_kW,
  output logic [1:0]       out_stride,
  output logic [7:0]       out_pad,
  output logic [3:0]       out_flags,
  output logic [DIM_W-1:0] out_padded_R,
  output logic [DIM_W-1:0] out_padded_C,
  output logic [DIM_W-1:0] out_R,
  output logic [DIM_W-1:0] out_C,
  output logic [7:0]       out_tile_D,
  output logic [7:0]       out_tile_K,
  output logic [CH_W-1:0]  out_ntile_D,
  output logic [CH_W-1:0]  out_ntile_K,
  output logic             out_err
);

  localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int AW1 = AW + 1;
  localparam logic [AW:0] DEPTH = AW1'(FIFO_DEPTH);
  localparam logic [7:0] T_PW  = 8'(TILE_PW);
  localparam logic [7:0] T_DW  = 8'(TILE_DW);
  localparam logic [7:0] T_STD = 8'(TILE_STD);

  typedef struct packed {
    uld_t             hdr;
    logic [DIM_W-1:0] r;
    logic [DIM_W-1:0] c;
    logic [CH_W-1:0]  d;
    logic [CH_W-1:0]  k;
  } ent_t;

  state_t state, state_nx;

  ent_t          mem [FIFO_DEPTH];
  ent_t          in_ent;
  ent_t          head;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  logic [DIM_W-1:0] pr_hd;
  logic [DIM_W-1:0] pc_hd;
  logic [15:0]      tiles_hd;
  logic             err_hd;

  uld_t             w_hdr;
  logic [CH_W-1:0]  w_d;
  logic [CH_W-1:0]  w_k;
  logic [DIM_W-1:0] w_pr;
  logic [DIM_W-1:0] w_pc;
  uld_dec_t         dec;
  logic [DIM_W-1:0] o_r;
  logic [DIM_W-1:0] o_c;
  logic [CH_W-1:0]  o_nd;
  logic [CH_W-1:0]  o_nk;

  logic             div_start;
  logic [CH_W-1:0]  div_a;
  logic [CH_W-1:0]  div_b;
  logic             div_busy;
  logic             div_done;
  logic [CH_W-1:0]  div_q;
  logic [DIM_W-1:0] diff_r;
  logic [DIM_W-1:0] diff_c;

  assign full     = (count == DEPTH);
  assign empty    = (count == '0);
  assign in_ready = !full;
  assign push     = in_valid && !full;
  assign pop      = (state == S_IDLE) && !empty;
  assign head     = mem[rd_ptr];

  always_comb begin
    in_ent.hdr.layer_id = in_layer_id;
    in_ent.hdr.ltype    = layer_t'(in_type);
    in_ent.hdr.kh       = in_kH;
    in_ent.hdr.kw       = in_kW;
    in_ent.hdr.stride   = in_stride;
    in_ent.hdr.pad      = in_pad;
    in_ent.hdr.flags    = in_flags;
    in_ent.r            = in_R;
    in_ent.c            = in_C;
    in_ent.d            = in_D;
    in_ent.k            = in_K;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_ent;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + AW1'(push) - AW1'(pop);
    end
  end

  // pad = {T,B,L,R}; sums wrap at DIM_W
  always_comb begin
    pr_hd = head.r + DIM_W'(head.hdr.pad[7:6])
                   + DIM_W'(head.hdr.pad[5:4]);
    pc_hd = head.c + DIM_W'(head.hdr.pad[3:2])
                   + DIM_W'(head.hdr.pad[1:0]);
    tiles_hd = tile_pair(head.hdr.ltype, T_PW, T_DW, T_STD);
`ifdef ULD_ERR_CHECK_EN
    err_hd = (head.hdr.stride == 2'd0)
          || (pr_hd < DIM_W'(head.hdr.kh))
          || (pc_hd < DIM_W'(head.hdr.kw))
          || (head.d == '0)
          || (head.k == '0);
`else
    err_hd = 1'b0;
`endif
  end

  assign diff_r = w_pr - DIM_W'(w_hdr.kh);
  assign diff_c = w_pc - DIM_W'(w_hdr.kw);

  // the done cycle of one division is the start cycle of the next
  always_comb begin
    div_start = 1'b0;
    div_a     = '0;
    div_b     = '0;
    unique case (state)
      S_DIV_R: begin
        if (!dec.err && !div_busy) begin
          div_start = 1'b1;
          div_a = div_done ? CH_W'(diff_c) : CH_W'(diff_r);
          div_b = CH_W'(w_hdr.stride);
        end
      end
      S_DIV_C: begin
        if (div_done) begin
          div_start = 1'b1;
          div_a = w_d + CH_W'(dec.tile_d) - CH_W'(1);
          div_b = CH_W'(dec.tile_d);
        end
      end
      S_DIV_TD: begin
        if (div_done) begin
          div_start = 1'b1;
          div_a = w_k + CH_W'(dec.tile_k) - CH_W'(1);
          div_b = CH_W'(dec.tile_k);
        end
      end
      default: ;
    endcase
  end

  uld_seq_div #(.W(CH_W)) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .dividend (div_a),
    .divisor  (div_b),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:   if (!empty) state_nx = S_DIV_R;
      S_DIV_R: begin
        if (dec.err)       state_nx = S_HOLD;
        else if (div_done) state_nx = S_DIV_C;
      end
      S_DIV_C:  if (div_done) state_nx = S_DIV_TD;
      S_DIV_TD: if (div_done) state_nx = S_DIV_TK;
      S_DIV_TK: if (div_done) state_nx = S_HOLD;
      S_HOLD:   if (out_ready) state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_hdr <= '0;
      w_d   <= '0;
      w_k   <= '0;
      w_pr  <= '0;
      w_pc  <= '0;
      dec   <= '0;
      o_r   <= '0;
      o_c   <= '0;
      o_nd  <= '0;
      o_nk  <= '0;
    end else begin
      if (pop) begin
        w_hdr      <= head.hdr;
        w_d        <= head.d;
        w_k        <= head.k;
        w_pr       <= pr_hd;
        w_pc       <= pc_hd;
        dec.tile_d <= tiles_hd[15:8];
        dec.tile_k <= tiles_hd[7:0];
        dec.err    <= err_hd;
        o_r        <= '0;
        o_c        <= '0;
        o_nd       <= '0;
        o_nk       <= '0;
      end
      if (div_done) begin
        unique case (state)
          S_DIV_R:  o_r  <= DIM_W'(div_q + CH_W'(1));
          S_DIV_C:  o_c  <= DIM_W'(div_q + CH_W'(1));
          S_DIV_TD: o_nd <= div_q;
          S_DIV_TK: o_nk <= div_q;
          default: ;
        endcase
      end
    end
  end

  assign out_valid    = (state == S_HOLD);
  assign out_layer_id = w_hdr.layer_id;
  assign out_type     = w_hdr.ltype;
  assign out_kH       = w_hdr.kh;
  assign out_kW       = w_hdr.kw;
  assign out_stride   = w_hdr.stride;
  assign out_pad      = w_hdr.pad;
  assign out_flags    = w_hdr.flags;
  assign out_padded_R = w_pr;
  assign out_padded_C = w_pc;
  assign out_R        = o_r;
  assign out_C        = o_c;
  assign out_tile_D   = dec.tile_d;
  assign out_tile_K   = dec.tile_k;
  assign out_ntile_D  = o_nd;
  assign out_ntile_K  = o_nk;
`ifdef ULD_ERR_CHECK_EN
  assign out_err      = dec.err;
`else
  assign out_err      = 1'b0;
`endif

endmodule

// File: tb/tb_uld_decode_pipe.sv
// tb_uld_decode_pipe: vector table + scoreboard bench for uld_decode_pipe.
// Covers latency, throughput, backpressure, wrap, stride 0, mid-op reset.
module tb_uld_decode_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid, in_ready;
  logic [5:0]  in_layer_id;
  logic [1:0]  in_type;
  logic [7:0]  in_R, in_C;
  logic [10:0] in_D, in_K;
  logic [1:0]  in_kH, in_kW, in_stride;
  logic [7:0]  in_pad;
  logic [3:0]  in_flags;
  logic        out_valid, out_ready;
  logic [5:0]  out_layer_id;
  logic [1:0]  out_type, out_kH, out_kW, out_stride;
  logic [7:0]  out_pad;
  logic [3:0]  out_flags;
  logic [7:0]  out_padded_R, out_padded_C, out_R, out_C;
  logic [7:0]  out_tile_D, out_tile_K;
  logic [10:0] out_ntile_D, out_ntile_K;
  logic        out_err;

  uld_decode_pipe #(
    .DIM_W(8), .CH_W(11), .FIFO_DEPTH(2),
    .TILE_PW(32), .TILE_DW(10), .TILE_STD(10)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_layer_id(in_layer_id), .in_type(in_type),
    .in_R(in_R), .in_C(in_C), .in_D(in_D), .in_K(in_K),
    .in_kH(in_kH), .in_kW(in_kW), .in_stride(in_stride),
    .in_pad(in_pad), .in_flags(in_flags),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_layer_id(out_layer_id), .out_type(out_type),
    .out_kH(out_kH), .out_kW(out_kW), .out_stride(out_stride),
    .out_pad(out_pad), .out_flags(out_flags),
    .out_padded_R(out_padded_R), .out_padded_C(out_padded_C),
    .out_R(out_R), .out_C(out_C),
    .out_tile_D(out_tile_D), .out_tile_K(out_tile_K),
    .out_ntile_D(out_ntile_D), .out_ntile_K(out_ntile_K),
    .out_err(out_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  id;
    logic [1:0]  ty;
    logic [7:0]  r, c;
    logic [10:0] d, k;
    logic [1:0]  kh, kw, st;
    logic [7:0]  pad;
    logic [3:0]  fl;
    logic [7:0]  e_pr, e_pc, e_or, e_oc, e_td, e_tk;
    logic [10:0] e_nd, e_nk;
    logic        e_err;
  } vec_t;

  vec_t tbl [8];
  vec_t sbq [$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   acc_n = 0;
  int   last_acc = 0;
  int   prev_acc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input int id, ty, r, c, d, k, kh, kw, st, pad, fl,
    input int pr, pc, o_r, o_c, td, tk, nd, nk, er);
    vec_t v;
    v.id = 6'(id);  v.ty = 2'(ty);
    v.r = 8'(r);    v.c = 8'(c);
    v.d = 11'(d);   v.k = 11'(k);
    v.kh = 2'(kh);  v.kw = 2'(kw); v.st = 2'(st);
    v.pad = 8'(pad); v.fl = 4'(fl);
    v.e_pr = 8'(pr); v.e_pc = 8'(pc);
    v.e_or = 8'(o_r); v.e_oc = 8'(o_c);
    v.e_td = 8'(td); v.e_tk = 8'(tk);
    v.e_nd = 11'(nd); v.e_nk = 11'(nk);
    v.e_err = 1'(er);
    return v;
  endfunction

  // reference arithmetic for legal descriptors with nonzero stride
  function automatic vec_t model(input vec_t v);
    vec_t m;
    int pr, pc, td, tk;
    m = v;
    pr = (int'(v.r) + int'(v.pad[7:6]) + int'(v.pad[5:4])) % 256;
    pc = (int'(v.c) + int'(v.pad[3:2]) + int'(v.pad[1:0])) % 256;
    case (v.ty)
      2'd1:    begin td = 1;  tk = 10; end
      2'd2:    begin td = 10; tk = 10; end
      default: begin td = 32; tk = 32; end
    endcase
    m.e_pr = 8'(pr);
    m.e_pc = 8'(pc);
    m.e_or = 8'(((pr - int'(v.kh) + 256) % 256) / int'(v.st) + 1);
    m.e_oc = 8'(((pc - int'(v.kw) + 256) % 256) / int'(v.st) + 1);
    m.e_td = 8'(td);
    m.e_tk = 8'(tk);
    m.e_nd = 11'(((int'(v.d) + td - 1) % 2048) / td);
    m.e_nk = 11'(((int'(v.k) + tk - 1) % 2048) / tk);
    m.e_err = 1'b0;
    return m;
  endfunction

  always @(negedge clk) begin : mon
    vec_t e;
    if (rst_n && out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output id=%0d required=none",
                 out_layer_id);
      end else begin
        e = sbq.pop_front();
        chk("pass",
            {out_layer_id, out_type, out_kH, out_kW,
             out_stride, out_pad, out_flags},
            {e.id, e.ty, e.kh, e.kw, e.st, e.pad, e.fl});
        chk("padded", {out_padded_R, out_padded_C}, {e.e_pr, e.e_pc});
        chk("dims", {out_R, out_C}, {e.e_or, e.e_oc});
        chk("tiles", {out_tile_D, out_tile_K}, {e.e_td, e.e_tk});
        chk("ntiles", {out_ntile_D, out_ntile_K}, {e.e_nd, e.e_nk});
        chk("err", out_err, e.e_err);
      end
      acc_n++;
      prev_acc = last_acc;
      last_acc = cyc;
    end
  end

  task automatic drive(input vec_t v);
    in_layer_id = v.id; in_type = v.ty;
    in_R = v.r; in_C = v.c; in_D = v.d; in_K = v.k;
    in_kH = v.kh; in_kW = v.kw; in_stride = v.st;
    in_pad = v.pad; in_flags = v.fl;
  endtask

  task automatic send(input vec_t v);
    int t;
    drive(v);
    in_valid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL send_timeout id=%0d in_ready=0 required=1", v.id);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      sbq.push_back(v);
      #1 in_valid = 1'b0;
    end
  endtask

  task automatic drain(input string nm);
    int t;
    t = 0;
    while (sbq.size() != 0 && t < 3000) begin
      @(posedge clk);
      t++;
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL %s_drain left=%0d required=0", nm, sbq.size());
      sbq.delete();
    end
  endtask

  initial begin : main
    vec_t rv;
    int   n;
    int   acc0;

    tbl[0] = mk(1, 0, 56, 56, 64, 128, 1, 1, 1, 8'h00, 1,
                56, 56, 56, 56, 32, 32, 2, 4, 0);
    tbl[1] = mk(2, 1, 112, 112, 32, 32, 3, 3, 2, 8'h55, 2,
                114, 114, 56, 56, 1, 10, 32, 4, 0);
    tbl[2] = mk(3, 2, 7, 7, 1, 1, 1, 1, 1, 8'h00, 4,
                7, 7, 7, 7, 10, 10, 1, 1, 0);
    tbl[3] = mk(4, 3, 1, 1, 100, 33, 1, 1, 1, 8'h00, 8,
                1, 1, 1, 1, 32, 32, 4, 2, 0);
`ifdef ULD_ERR_CHECK_EN
    tbl[4] = mk(5, 0, 10, 10, 8, 8, 1, 1, 0, 8'h00, 3,
                10, 10, 0, 0, 32, 32, 0, 0, 1);
    tbl[7] = mk(7, 1, 255, 250, 2047, 1, 1, 1, 1, 8'hFF, 5,
                5, 0, 0, 0, 1, 10, 0, 0, 1);
`else
    tbl[4] = mk(5, 0, 10, 10, 8, 8, 1, 1, 0, 8'h00, 3,
                10, 10, 0, 0, 32, 32, 1, 1, 0);
    tbl[7] = mk(7, 1, 255, 250, 2047, 1, 1, 1, 1, 8'hFF, 5,
                5, 0, 5, 0, 1, 10, 2047, 1, 0);
`endif
    tbl[5] = mk(6, 2, 20, 15, 20, 25, 3, 2, 3, 8'h9C, 6,
                23, 18, 7, 6, 10, 10, 2, 3, 0);
    tbl[6] = mk(8, 0, 9, 8, 32, 33, 2, 3, 2, 8'h00, 9,
                9, 8, 4, 3, 32, 32, 1, 2, 0);

    in_valid = 1'b0;
    out_ready = 1'b1;
    drive(tbl[0]);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid_ready", {out_valid, in_ready}, 2'b01);
    chk("rst_dims",
        {out_R, out_C, out_padded_R, out_padded_C,
         out_tile_D, out_tile_K}, 48'h0);
    chk("rst_nt", {out_ntile_D, out_ntile_K, out_err}, 23'h0);
    chk("rst_pass",
        {out_layer_id, out_type, out_kH, out_kW,
         out_stride, out_pad, out_flags}, 26'h0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    send(tbl[0]);
    n = 0;
    while (n < 200) begin
      @(posedge clk);
      n++;
      #1;
      if (out_valid) break;
    end
    chk("latency", n, 46);
    drain("pw");

    for (int i = 1; i < 8; i++) send(tbl[i]);
    drain("table");

    for (int i = 0; i < 6; i++) begin
      rv.id = 6'(16 + i);
      rv.ty = 2'($urandom_range(0, 3));
      rv.r  = 8'($urandom_range(4, 240));
      rv.c  = 8'($urandom_range(4, 240));
      rv.d  = 11'($urandom_range(1, 2047));
      rv.k  = 11'($urandom_range(1, 2047));
      rv.kh = 2'($urandom_range(1, 3));
      rv.kw = 2'($urandom_range(1, 3));
      rv.st = 2'($urandom_range(1, 3));
      rv.pad = 8'($urandom);
      rv.fl  = 4'($urandom);
      send(model(rv));
    end
    drain("random");

    send(tbl[0]);
    send(tbl[2]);
    drain("thru");
    chk("throughput", last_acc - prev_acc, 47);

    out_ready = 1'b0;
    send(tbl[1]);
    send(tbl[2]);
    send(tbl[3]);
    @(negedge clk);
    chk("bp_in_ready", in_ready, 1'b0);
    rv = tbl[4];
    rv.id = 6'd63;
    drive(rv);
    in_valid = 1'b1;
    repeat (5) @(posedge clk);
    #1 in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 200) begin
      @(posedge clk);
      n++;
      #1;
    end
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("bp_hold", {out_valid, out_layer_id}, {1'b1, tbl[1].id});
    chk("bp_full", in_ready, 1'b0);
    @(posedge clk);
    #1 out_ready = 1'b1;
    drain("bp");
    repeat (100) @(posedge clk);

    send(tbl[0]);
    send(tbl[2]);
    repeat (15) @(posedge clk);
    #1 rst_n = 1'b0;
    sbq.delete();
    acc0 = acc_n;
    #1;
    chk("rst_mid", {out_valid, in_ready}, 2'b01);
    chk("rst_mid_dims", {out_R, out_ntile_D}, 19'h0);
    @(negedge clk) rst_n = 1'b1;
    repeat (150) @(posedge clk);
    #1;
    chk("rst_fifo_empty", acc_n - acc0, 0);
    send(tbl[5]);
    drain("after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
